// File: rtl/branch_predictor_unit_pkg.sv
// Shared definitions for the branch predictor: opcodes, counter init values
// and the PC index/tag extraction helpers.
package bpu_defs;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Weakly-taken threshold THR, and THR-1 (weakly not-taken) used at reset/flush.
  function automatic int unsigned ctr_thr(input int bits);
    return 32'(1) << (bits - 1);
  endfunction

  function automatic int unsigned ctr_init(input int bits);
    return (32'(1) << (bits - 1)) - 32'(1);
  endfunction

  // PCs are widened to 64 bits so the helpers serve any XLEN up to 64.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_bits);
    return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_bits,
                                         input int tag_bits);
    return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_unit_sat_ctr.sv
// W-bit saturating up/down counter with a synchronous load; load wins over
// inc, inc wins over dec.
module bp_sat_ctr #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         cpu_clk,
  input  logic         cpu_rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] ctr
);

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ctr <= RST_VAL;
    end else if (load) begin
      ctr <= load_val;
    end else if (inc && (ctr != {W{1'b1}})) begin
      ctr <= ctr + W'(1);
    end else if (dec && (ctr != '0)) begin
      ctr <= ctr - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with per-entry saturating counters: combinational lookup on
// the fetch PC, update and mispredict detection on the resolved EX instruction.
module branch_predictor_unit
  import bpu_defs::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic            cpu_clk,
  input  logic            cpu_rstn,
  input  logic            tbl_flush,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  output logic [XLEN-1:0] if_npc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_mispredict,
  output logic [XLEN-1:0] ex_redirect_pc,
  input  logic            stat_clr,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] THR    = CTR_BITS'(ctr_thr(CTR_BITS));
  localparam logic [CTR_BITS-1:0] THR_M1 = CTR_BITS'(ctr_init(CTR_BITS));

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic                jump_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr      [ENTRIES];

  logic [IDX-1:0]      f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic                f_hit, u_hit;

  assign f_idx = IDX'(pc_index(64'(if_pc), IDX));
  assign f_tag = TAG_BITS'(pc_tag(64'(if_pc), IDX, TAG_BITS));
  assign u_idx = IDX'(pc_index(64'(ex_pc), IDX));
  assign u_tag = TAG_BITS'(pc_tag(64'(ex_pc), IDX, TAG_BITS));

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign if_pred_taken  = f_hit && (jump_q[f_idx] || ctr[f_idx][CTR_BITS-1]);
  assign if_pred_target = f_hit ? target_q[f_idx] : '0;
  assign if_npc         = if_pred_taken ? if_pred_target : if_pc + XLEN'(4);

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  logic ex_kind;
  assign ex_kind        = ex_is_branch || ex_is_jal || ex_is_jalr;
  assign ex_mispredict  = ex_valid && ((ex_pred_taken != ex_taken) ||
                                       (ex_taken && (ex_pred_target != ex_target)));
  assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

  // ex_valid qualifies all ex_* inputs for exactly one cycle; there is no ready,
  // every resolved instruction is accepted in the cycle it is presented.
  logic alloc, ctr_inc, ctr_dec, tgt_wr, set_jump, inval;

  always_comb begin
    alloc    = 1'b0;
    ctr_inc  = 1'b0;
    ctr_dec  = 1'b0;
    tgt_wr   = 1'b0;
    set_jump = 1'b0;
    inval    = 1'b0;
    if (ex_valid && !tbl_flush) begin
      if (ex_is_jalr) begin
        inval = u_hit;
      end else if (ex_is_jal) begin
        if (u_hit) begin
          tgt_wr   = 1'b1;
          set_jump = 1'b1;
        end else begin
          alloc = 1'b1;
        end
      end else if (ex_is_branch) begin
        if (u_hit) begin
          ctr_inc = ex_taken;
          ctr_dec = !ex_taken;
          tgt_wr  = ex_taken;
        end else begin
          alloc = ex_taken;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
      end
    end else if (tbl_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (alloc) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= ex_target;
      jump_q[u_idx]   <= ex_is_jal;
    end else begin
      if (tgt_wr)   target_q[u_idx] <= ex_target;
      if (set_jump) jump_q[u_idx]   <= 1'b1;
      if (inval)    valid_q[u_idx]  <= 1'b0;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic sel;
    assign sel = (u_idx == IDX'(g));
    bp_sat_ctr #(
      .W       (CTR_BITS),
      .RST_VAL (THR_M1)
    ) u_ctr (
      .cpu_clk  (cpu_clk),
      .cpu_rstn (cpu_rstn),
      .load     (tbl_flush || (alloc && sel)),
      .load_val (tbl_flush ? THR_M1 : THR),
      .inc      (ctr_inc && sel),
      .dec      (ctr_dec && sel),
      .ctr      (ctr[g])
    );
  end

  // Kind-less ex_valid cycles leave the statistics untouched.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (ex_valid && ex_kind)      stat_branches    <= stat_branches + 32'd1;
      if (ex_mispredict && ex_kind) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Dynamic branch predictor for the 5-stage RV32I pipeline. Replaces the fixed "always not-taken, flush two stages" policy with a direct-mapped BTB and per-entry saturating counters.
- IF-side lookup is combinational on the fetch PC, so the redirect is valid in the same cycle as the asynchronous instruction-memory read.
- EX-side update runs on resolved branch/jal/jalr and produces the mispredict flag and redirect PC consumed by the hazard logic.
- Also provides resolved-branch and mispredict statistics counters for the debug bus.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, number of BTB entries; power of 2, >= 2. IDX = log2(ENTRIES).
- TAG_BITS, 8, stored tag width. Tag = pc[IDX+2 +: TAG_BITS]; requires IDX+2+TAG_BITS <= XLEN.
- CTR_BITS, 2, saturating counter width; >= 1. THR = 1 << (CTR_BITS-1).

Ports:
- cpu_clk, in, 1, clock.
- cpu_rstn, in, 1, reset.
- tbl_flush, in, 1, synchronous clear of all valid bits and counters.
- if_pc, in, XLEN, fetch PC.
- if_pred_taken, out, 1, predicted taken for if_pc.
- if_pred_target, out, XLEN, stored target; 0 on miss.
- if_npc, out, XLEN, if_pred_taken ? if_pred_target : if_pc+4.
- ex_valid, in, 1, EX holds a resolved control-transfer instruction (not a bubble).
- ex_pc, in, XLEN, PC of the EX instruction.
- ex_is_branch, in, 1, conditional branch.
- ex_is_jal, in, 1, jal.
- ex_is_jalr, in, 1, jalr.
- ex_taken, in, 1, actual outcome (1 for jal/jalr).
- ex_target, in, XLEN, actual target; for jalr, LSB already cleared.
- ex_pred_taken, in, 1, prediction carried down the pipe from IF.
- ex_pred_target, in, XLEN, predicted target carried down the pipe.
- ex_mispredict, out, 1, flush IF/ID and ID/EX.
- ex_redirect_pc, out, XLEN, ex_taken ? ex_target : ex_pc+4.
- stat_clr, in, 1, synchronous clear of the statistics counters.
- stat_branches, out, 32, resolved control transfers.
- stat_mispredicts, out, 32, mispredicts.

Behaviour:
- Reset: cpu_rstn is asynchronous, active-low; clock is cpu_clk. Reset clears all valid bits, tags, targets and jump flags to 0, sets every counter to THR-1 (weakly not-taken), and clears both statistics counters to 0.
- Outputs at reset with if_pc=0: if_pred_taken=0, if_pred_target=0, if_npc=4. ex_mispredict is 0 whenever ex_valid=0.
- Lookup (combinational, zero latency):
  - idx = if_pc[IDX+1:2].
  - hit = valid[idx] && tag[idx] == tag(if_pc).
  - if_pred_taken = hit && (jump[idx] || ctr[idx][CTR_BITS-1]).
  - if_pred_target = hit ? target[idx] : 0.
- Mispredict (combinational):
  - ex_mispredict = ex_valid && (ex_pred_taken != ex_taken || (ex_taken && ex_pred_target != ex_target)).
  - Applies to all three instruction kinds, including jalr.
- Update: on the cpu_clk edge when ex_valid, indexed by ex_pc.
  - Hit on a branch:
    - taken: ctr increments, saturating at 2^CTR_BITS-1; target <= ex_target.
    - not taken: ctr decrements, saturating at 0; target unchanged.
  - Hit on jal: target <= ex_target; jump=1.
  - Miss, taken branch or jal: allocate (overwrite). valid=1, tag=tag(ex_pc), target=ex_target, jump=ex_is_jal, ctr=THR (weakly taken).
  - Miss, not-taken branch: no allocation.
  - jalr: never allocated. A jalr that hits (tag alias) clears valid[idx].
  - ex_valid with none of the three kind flags set: no table or statistics change.
- Simultaneous lookup and update to the same idx: lookup returns the pre-update contents; there is no bypass.
- Priority:
  - tbl_flush beats a same-cycle update.
  - stat_clr beats a same-cycle increment.
  - tbl_flush does not clear the statistics counters.
- Statistics:
  - stat_branches += 1 per ex_valid with any kind flag set.
  - stat_mispredicts += 1 per ex_mispredict.
  - Both wrap modulo 2^32.
- PC arithmetic (if_pc+4, ex_pc+4) is modulo 2^XLEN; 0xFFFFFFFC+4 = 0.
- Reset mid-operation: all state returns to reset values immediately. A pending update in that cycle is discarded.
- Stall: the block is stateless with respect to stall. The pipeline holds if_pc; the predictor output is stable while tables are unchanged.

Decomposition:
- Shared header/package bpu_defs: opcode constants (BRANCH 7'b1100011, JAL 7'b1101111, JALR 7'b1100111), counter-init macros THR and THR-1, and the index/tag extraction helper functions.
- One sub-module, bp_sat_ctr: a CTR_BITS-wide saturating up/down counter with load value, instantiated per entry via a generate loop.
- Statistics counters are inline.

Test Plan:
- Reset, then if_pc=0x40 -> if_pred_taken=0, if_npc=0x44, stat_branches=0, all counters = 01.
- Taken branch at 0x40, target 0x20, pred 0 -> ex_mispredict=1, ex_redirect_pc=0x20. Next cycle, lookup 0x40 -> taken, target 0x20, ctr=10.
- Same branch resolved not-taken twice -> ctr 10->01->00. Lookup 0x40 -> not taken, if_npc=0x44. Third not-taken -> ctr stays 00, no mispredict when pred=0.
- jal at 0x100, target 0x200 -> allocated with jump=1. Lookup 0x100 -> taken regardless of ctr. A jalr at 0x100+ENTRIES*4*2^TAG_BITS (alias) -> entry invalidated.
- Same-cycle lookup and update at idx of 0x40 -> lookup shows old value. tbl_flush with update in the same cycle -> table empty. stat_clr with mispredict in the same cycle -> stat_mispredicts=0.
- Preload stat_branches to 0xFFFFFFFF, resolve one branch -> wraps to 0. if_pc=0xFFFFFFFC miss -> if_npc=0.
